// File: rtl/apb_req_scheduler_pkg.sv
// Shared types for the APB request scheduler: FSM state encoding and a
// constant-evaluable clog2 used to size index and counter fields.
package apb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } sched_state_t;

  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/apb_req_scheduler_if.sv
// APB3 bus bundle between the scheduler (master) and the shared peripheral
// bus (slave).
interface apb_req_scheduler_if #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
);

  logic                 PSEL;
  logic                 PENABLE;
  logic                 PWRITE;
  logic [ADDRWIDTH-1:0] PADDR;
  logic [DATAWIDTH-1:0] PWDATA;
  logic [DATAWIDTH-1:0] PRDATA;
  logic                 PREADY;
  logic                 PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_req_scheduler_arb.sv
// Combinational round-robin pick: lowest requester strictly above the
// pointer wins, otherwise wrap around to the lowest requester overall.
module apb_rr_arbiter
  import apb_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             hi_any;
  logic             lo_any;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;

  // Scanning downward leaves the lowest matching index in each candidate
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_any = 1'b1;
        lo_idx = IDX_W'(i);
        if (i > int'(ptr)) begin
          hi_any = 1'b1;
          hi_idx = IDX_W'(i);
        end
      end
    end
    idx   = hi_any ? hi_idx : lo_idx;
    grant = lo_any ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/apb_req_scheduler.sv
// Round-robin scheduler sharing one APB3 master port between NUM_REQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES enabled wait edges.
module apb_req_scheduler
  import apb_sched_pkg::*;
#(
  parameter  int NUM_REQ        = 4,
  parameter  int ADDRWIDTH      = 16,
  parameter  int DATAWIDTH      = 32,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int IDX_W          = clog2(NUM_REQ)
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           PCLKEN,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [DATAWIDTH-1:0]           rsp_rdata,
  output logic                           rsp_err,
  output logic                           busy,
  output logic [IDX_W-1:0]               grant_id,
  apb_req_scheduler_if.master            apb
);

  sched_state_t         state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_REQ-1:0]   pick_grant;
  logic                 pick_any;
  logic                 complete;
  logic                 abort;
  logic                 done;
  logic                 psel_q;
  logic                 penable_q;
  logic                 pwrite_q;
  logic [ADDRWIDTH-1:0] paddr_q;
  logic [DATAWIDTH-1:0] pwdata_q;
  logic [ADDRWIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATAWIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDRWIDTH +: ADDRWIDTH];
    assign wdata_arr[g] = req_wdata[g*DATAWIDTH +: DATAWIDTH];
  end

  apb_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  assign pick_any = |pick_grant;
  assign complete = (state == ACCESS) && PCLKEN && apb.PREADY;
  assign done     = complete || abort;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] wait_cnt;

  assign abort = (state == ACCESS) && PCLKEN && !apb.PREADY &&
                 (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (PCLKEN) begin
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !apb.PREADY && !abort) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Payload is latched at grant so a requester dropping valid mid-transfer is harmless
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      grant_id  <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
    end else if (PCLKEN) begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= SETUP;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            pwrite_q  <= req_write[pick_idx];
            paddr_q   <= addr_arr[pick_idx];
            pwdata_q  <= wdata_arr[pick_idx];
            grant_id  <= pick_idx;
            rr_ptr    <= pick_idx;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            state     <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign apb.PSEL    = psel_q;
  assign apb.PENABLE = penable_q;
  assign apb.PWRITE  = pwrite_q;
  assign apb.PADDR   = paddr_q;
  assign apb.PWDATA  = pwdata_q;

  assign busy      = (state != IDLE);
  assign req_ready = done ? (NUM_REQ'(1) << grant_id) : '0;
  assign rsp_rdata = (complete && !pwrite_q) ? apb.PRDATA : '0;
  assign rsp_err   = complete ? apb.PSLVERR : abort;

endmodule

// File: tb/tb_apb_req_scheduler.sv
// Self-checking bench for apb_req_scheduler: transaction-level model checked
// every cycle plus directed scenarios with hand-computed expectations.
module tb_apb_req_scheduler;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef APB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic            HCLK    = 1'b0;
  logic            HRESETn = 1'b0;
  logic            PCLKEN  = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            busy;
  logic [1:0]      grant_id;

  logic [AW-1:0]   addr_tab  [N];
  logic [DW-1:0]   wdata_tab [N];

  int checks       = 0;
  int errors       = 0;
  int ready_pulses = 0;
  bit clken_div    = 1'b0;
  int slave_wait   = 0;

  apb_req_scheduler_if #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) apb_bus ();

  apb_req_scheduler #(
    .NUM_REQ        (N),
    .ADDRWIDTH      (AW),
    .DATAWIDTH      (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PCLKEN    (PCLKEN),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .grant_id  (grant_id),
    .apb       (apb_bus)
  );

  always #5 HCLK = ~HCLK;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr_tab[i];
      req_wdata[i*DW +: DW] = wdata_tab[i];
    end
  end

  // Transaction-level reference: who is being served and how many enabled edges it has seen
  bit            m_active;
  int            m_edges;
  int            m_gid;
  int            m_ptr;
  int            m_waits;
  logic [AW-1:0] m_addr;
  logic          m_write;
  logic [DW-1:0] m_wdata;
  int            nxt;
  bit            timeout_now;
  bit            exp_done;
  logic [N-1:0]  exp_ready;
  logic [DW-1:0] exp_rdata;
  logic          exp_err;

  function automatic int pick_next(input logic [N-1:0] v, input int from);
    int r;
    r = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (from + k) % N;
      if (r < 0 && v[c[1:0]]) r = c;
    end
    return r;
  endfunction

  always_comb nxt = pick_next(req_valid, m_ptr);

  always_comb begin
    timeout_now = TIMEOUT_EN && m_active && (m_edges >= 2) && !apb_bus.PREADY && (m_waits == TO - 1);
    exp_done    = m_active && (m_edges >= 2) && PCLKEN && (apb_bus.PREADY || timeout_now);
    exp_ready   = exp_done ? (N'(1) << m_gid) : '0;
    exp_rdata   = (apb_bus.PREADY && !m_write) ? apb_bus.PRDATA : '0;
    exp_err     = apb_bus.PREADY ? apb_bus.PSLVERR : 1'b1;
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_active <= 1'b0;
      m_edges  <= 0;
      m_gid    <= 0;
      m_ptr    <= N - 1;
      m_waits  <= 0;
      m_addr   <= '0;
      m_write  <= 1'b0;
      m_wdata  <= '0;
    end else if (PCLKEN) begin
      if (!m_active) begin
        if (nxt >= 0) begin
          m_active <= 1'b1;
          m_edges  <= 1;
          m_gid    <= nxt;
          m_ptr    <= nxt;
          m_addr   <= addr_tab[nxt[1:0]];
          m_write  <= req_write[nxt[1:0]];
          m_wdata  <= wdata_tab[nxt[1:0]];
        end
      end else if (m_edges == 1) begin
        m_edges <= 2;
        m_waits <= 0;
      end else if (apb_bus.PREADY || timeout_now) begin
        m_active <= 1'b0;
      end else begin
        m_waits <= m_waits + 1;
      end
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (HRESETn) begin
      check_output("psel",     64'(apb_bus.PSEL),    64'(m_active));
      check_output("penable",  64'(apb_bus.PENABLE), 64'(m_active && (m_edges >= 2)));
      check_output("paddr",    64'(apb_bus.PADDR),   64'(m_addr));
      check_output("pwrite",   64'(apb_bus.PWRITE),  64'(m_write));
      check_output("pwdata",   64'(apb_bus.PWDATA),  64'(m_wdata));
      check_output("busy",     64'(busy),            64'(m_active));
      check_output("grant_id", 64'(grant_id),        64'(m_gid));
      check_output("req_ready", 64'(req_ready),      64'(exp_ready));
      if (exp_done) begin
        check_output("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check_output("rsp_err",   64'(rsp_err),   64'(exp_err));
      end
      if (|req_ready) ready_pulses <= ready_pulses + 1;
    end
  end

  // PCLKEN is either held high or toggled to give a 1-in-2 enable
  initial begin
    forever begin
      @(posedge HCLK);
      #1;
      PCLKEN = clken_div ? ~PCLKEN : 1'b1;
    end
  end

  // Slave inserts slave_wait enabled ACCESS edges with PREADY low before completing
  initial begin
    int  wcnt;
    bit  acc_n, en_n, rdy_n;
    wcnt = 0;
    apb_bus.PREADY  = 1'b0;
    apb_bus.PRDATA  = '0;
    apb_bus.PSLVERR = 1'b0;
    forever begin
      @(negedge HCLK);
      acc_n = apb_bus.PSEL && apb_bus.PENABLE;
      en_n  = PCLKEN;
      rdy_n = apb_bus.PREADY;
      @(posedge HCLK);
      #1;
      if (!(apb_bus.PSEL && apb_bus.PENABLE)) wcnt = 0;
      else if (acc_n && en_n && !rdy_n) wcnt++;
      apb_bus.PREADY = (apb_bus.PSEL && apb_bus.PENABLE) && (wcnt >= slave_wait);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input int i, input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]  = v;
    req_write[i]  = w;
    addr_tab[i]   = a;
    wdata_tab[i]  = d;
  endtask

  task automatic reset_dut();
    HRESETn = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
  endtask

  task automatic wait_ready(output int idx, output int n, output logic [DW-1:0] rd, output logic er);
    bit seen;
    seen = 1'b0;
    idx  = -1;
    n    = 0;
    rd   = '0;
    er   = 1'b0;
    for (int c = 1; c <= 50 && !seen; c++) begin
      @(negedge HCLK);
      if (|req_ready) begin
        seen = 1'b1;
        n    = c;
        rd   = rsp_rdata;
        er   = rsp_err;
        for (int k = 0; k < N; k++) if (req_ready[k]) idx = k;
      end
    end
    if (!seen) check_output("ready_wait_bound", 64'(0), 64'(1));
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    int            idx, n, pulses0;
    logic [DW-1:0] rd;
    logic          er;

    req_valid = '0;
    req_write = '0;
    for (int i = 0; i < N; i++) begin
      addr_tab[i]  = '0;
      wdata_tab[i] = '0;
    end
    reset_dut();

    // Reset state
    @(negedge HCLK);
    check_output("rst_psel",    64'(apb_bus.PSEL),    64'(0));
    check_output("rst_penable", 64'(apb_bus.PENABLE), 64'(0));
    check_output("rst_paddr",   64'(apb_bus.PADDR),   64'(0));
    check_output("rst_busy",    64'(busy),            64'(0));
    check_output("rst_ready",   64'(req_ready),       64'(0));
    @(posedge HCLK);
    #1;

    // 1: single read, ready in the third cycle
    $display("[TB] single read");
    apb_bus.PRDATA = 32'hDEADBEEF;
    apply_stimulus(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    @(posedge HCLK);
    #1;
    check_output("t1_psel_e1",    64'(apb_bus.PSEL),    64'(1));
    check_output("t1_penable_e1", 64'(apb_bus.PENABLE), 64'(0));
    check_output("t1_paddr",      64'(apb_bus.PADDR),   64'h0010);
    @(posedge HCLK);
    #1;
    check_output("t1_penable_e2", 64'(apb_bus.PENABLE), 64'(1));
    @(negedge HCLK);
    check_output("t1_ready", 64'(req_ready), 64'h1);
    check_output("t1_rdata", 64'(rsp_rdata), 64'hDEADBEEF);
    check_output("t1_err",   64'(rsp_err),   64'(0));
    @(posedge HCLK);
    #1;
    apply_stimulus(0, 1'b0, 1'b0, 16'h0010, 32'h0);
    check_output("t1_psel_idle", 64'(apb_bus.PSEL), 64'(0));

    // 2: all four valid after reset are served in order 0..3
    $display("[TB] simultaneous requests");
    reset_dut();
    for (int i = 0; i < N; i++) apply_stimulus(i, 1'b1, 1'b0, AW'((i + 1) * 16'h0100), 32'h0);
    for (int k = 0; k < N; k++) begin
      wait_ready(idx, n, rd, er);
      check_output("t2_order",   64'(idx), 64'(k));
      check_output("t2_latency", 64'(n),   64'(3));
      check_output("t2_paddr",   64'(apb_bus.PADDR), 64'((k + 1) * 256));
      if (idx >= 0) req_valid[idx] = 1'b0;
    end

    // 3: half-rate PCLKEN and three wait states give exactly one ready pulse
    $display("[TB] half-rate enable with wait states");
    clken_div      = 1'b1;
    slave_wait     = 3;
    apb_bus.PRDATA = 32'hCAFEF00D;
    pulses0        = ready_pulses;
    apply_stimulus(0, 1'b1, 1'b0, 16'h0020, 32'h0);
    wait_ready(idx, n, rd, er);
    req_valid[0] = 1'b0;
    repeat (6) @(negedge HCLK);
    check_output("t3_idx",    64'(idx), 64'(0));
    check_output("t3_rdata",  64'(rd),  64'hCAFEF00D);
    check_output("t3_pulses", 64'(ready_pulses - pulses0), 64'(1));
    clken_div  = 1'b0;
    slave_wait = 0;
    @(posedge HCLK);
    #1;

    // 4: slave error on a write, then a clean read
    $display("[TB] slave error");
    apb_bus.PSLVERR = 1'b1;
    apb_bus.PRDATA  = 32'hFFFF0000;
    apply_stimulus(1, 1'b1, 1'b1, 16'h0044, 32'h12345678);
    wait_ready(idx, n, rd, er);
    req_valid[1] = 1'b0;
    check_output("t4_idx",    64'(idx), 64'(1));
    check_output("t4_err",    64'(er),  64'(1));
    check_output("t4_rdata",  64'(rd),  64'(0));
    check_output("t4_pwdata", 64'(apb_bus.PWDATA), 64'h12345678);
    apb_bus.PSLVERR = 1'b0;
    apply_stimulus(2, 1'b1, 1'b0, 16'h0048, 32'h0);
    wait_ready(idx, n, rd, er);
    req_valid[2] = 1'b0;
    check_output("t4b_err",   64'(er), 64'(0));
    check_output("t4b_rdata", 64'(rd), 64'hFFFF0000);

    // 5: reset during ACCESS clears the bus at once; req0 wins afterwards
    $display("[TB] reset mid-transfer");
    slave_wait = 1000;
    apply_stimulus(2, 1'b1, 1'b0, 16'h0050, 32'h0);
    repeat (2) begin
      @(posedge HCLK);
      #1;
    end
    check_output("t5_penable_pre", 64'(apb_bus.PENABLE), 64'(1));
    #1;
    HRESETn = 1'b0;
    #1;
    check_output("t5_psel",    64'(apb_bus.PSEL),    64'(0));
    check_output("t5_penable", 64'(apb_bus.PENABLE), 64'(0));
    check_output("t5_ready",   64'(req_ready),       64'(0));
    apply_stimulus(0, 1'b1, 1'b0, 16'h0060, 32'h0);
    slave_wait = 0;
    repeat (2) @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    wait_ready(idx, n, rd, er);
    req_valid[0] = 1'b0;
    check_output("t5_first", 64'(idx), 64'(0));
    wait_ready(idx, n, rd, er);
    req_valid[2] = 1'b0;
    check_output("t5_second", 64'(idx), 64'(2));

    // 6: stuck slave
    $display("[TB] stuck slave");
    slave_wait     = 1000;
    apb_bus.PRDATA = 32'hA5A5A5A5;
    apply_stimulus(3, 1'b1, 1'b0, 16'h0070, 32'h0);
`ifdef APB_TIMEOUT_EN
    wait_ready(idx, n, rd, er);
    req_valid[3] = 1'b0;
    check_output("t6_idx",     64'(idx), 64'(3));
    check_output("t6_latency", 64'(n),   64'(6));
    check_output("t6_err",     64'(er),  64'(1));
    check_output("t6_rdata",   64'(rd),  64'(0));
    slave_wait = 0;
`else
    pulses0 = ready_pulses;
    repeat (40) @(negedge HCLK);
    check_output("t6_busy",   64'(busy), 64'(1));
    check_output("t6_pulses", 64'(ready_pulses - pulses0), 64'(0));
    slave_wait = 0;
    wait_ready(idx, n, rd, er);
    req_valid[3] = 1'b0;
    check_output("t6_idx",   64'(idx), 64'(3));
    check_output("t6_err",   64'(er),  64'(0));
    check_output("t6_rdata", 64'(rd),  64'hA5A5A5A5);
`endif

    repeat (3) @(posedge HCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
